// File: rtl/async_fifo_pkg.sv
// ============================================================================
//  Package     : async_fifo_pkg
//  Description : Shared Gray/binary conversion helpers and FIFO depth
//                derivation for the asynchronous FIFO pointer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    // Widest pointer supported (ADDRSIZE up to 16, plus the wrap bit)
    localparam int unsigned PTR_W_MAX = 17;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // FIFO depth for a given address width
    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    // One bit of the Gray code of a zero-extended binary value
    function automatic logic bin2gray_bit(input ptr_t b, input int unsigned idx);
        logic [1:0] w_pair;
        w_pair = 2'(b >> idx);
        return w_pair[0] ^ w_pair[1];
    endfunction

    // One bit of the binary value of a zero-extended Gray code:
    // binary bit i is the XOR of all Gray bits at or above i
    function automatic logic gray2bin_bit(input ptr_t g, input int unsigned idx);
        return ^(g >> idx);
    endfunction

endpackage : async_fifo_pkg

`default_nettype wire

// File: rtl/gray2bin.sv
// ============================================================================
//  Module      : gray2bin
//  Description : Combinational Gray-to-binary converter of parameterized
//                width (WIDTH <= 17).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic [PTR_W_MAX-1:0] w_gray_ext;

    assign w_gray_ext = ptr_t'(i_gray);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = gray2bin_bit(w_gray_ext, gi);
        end
    endgenerate

endmodule : gray2bin

`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-side pointer and full/almost-full/level control of an
//                asynchronous FIFO. Compares the next Gray write pointer
//                against the synchronized Gray read pointer.
//  Options     : define ASYNC_FIFO_OVF_EN to build the sticky overflow flag
//                (wovf); otherwise wovf is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_LVL = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                awfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam logic [ADDRSIZE:0] c_AFULL_THRESH =
        (ADDRSIZE+1)'(fifo_depth(ADDRSIZE) - AFULL_LVL);

    logic [ADDRSIZE:0]    r_wbin;
    logic [ADDRSIZE:0]    r_wptr;
    logic                 r_wfull;
    logic                 r_awfull;
    logic [ADDRSIZE:0]    r_wlevel;

    logic                 w_wr_accept;
    logic [ADDRSIZE:0]    w_wbinnext;
    logic [ADDRSIZE:0]    w_wgraynext;
    logic [ADDRSIZE:0]    w_rbin;
    logic [ADDRSIZE:0]    w_rptr_full_cmp;
    logic [ADDRSIZE:0]    w_wlevel_next;
    logic                 w_wfull_next;
    logic                 w_awfull_next;
    logic [PTR_W_MAX-1:0] w_wbinnext_ext;

    // Synchronized read pointer back to binary for level arithmetic
    gray2bin #(
        .WIDTH (ADDRSIZE+1)
    ) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin)
    );

    // A write attempted while full is dropped
    assign w_wr_accept    = winc & ~r_wfull;
    assign w_wbinnext     = r_wbin + {{ADDRSIZE{1'b0}}, w_wr_accept};
    assign w_wbinnext_ext = ptr_t'(w_wbinnext);

    generate
        for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_wgray
            assign w_wgraynext[gi] = bin2gray_bit(w_wbinnext_ext, gi);
        end
    endgenerate

    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its top two bits inverted
    assign w_rptr_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign w_wfull_next    = (w_wgraynext == w_rptr_full_cmp);

    assign w_wlevel_next   = w_wbinnext - w_rbin;
    assign w_awfull_next   = (w_wlevel_next >= c_AFULL_THRESH);

    // Pointer, flag and level registers
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_awfull <= 1'b0;
            r_wlevel <= '0;
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            r_wfull  <= w_wfull_next;
            r_awfull <= w_awfull_next;
            r_wlevel <= w_wlevel_next;
        end
    end

`ifdef ASYNC_FIFO_OVF_EN
    logic r_wovf;

    // Sticky overflow: any write request seen while full, held until reset
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wovf <= 1'b0;
        end else if (winc && r_wfull) begin
            r_wovf <= 1'b1;
        end
    end

    assign wovf = r_wovf;
`else
    assign wovf = 1'b0;
`endif

    assign waddr  = r_wbin[ADDRSIZE-1:0];
    assign wptr   = r_wptr;
    assign wfull  = r_wfull;
    assign awfull = r_awfull;
    assign wlevel = r_wlevel;

endmodule : wptr_full_ctrl

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Directed scoreboard bench for wptr_full_ctrl
//                (ADDRSIZE=4, AFULL_LVL=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wptr_full_ctrl;

    typedef struct packed {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       awfull;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       awfull;
    logic [4:0] wlevel;
    logic       wovf;

    int   errors = 0;
    int   checks = 0;
    exp_t q_exp[$];

    // Reference model state
    logic [4:0] m_bin;
    logic [4:0] m_rbin;
    logic [4:0] m_level;
    logic       m_full;
    logic       m_aw;
    logic       m_ovf;
    int         rb;

    wptr_full_ctrl #(
        .ADDRSIZE  (4),
        .AFULL_LVL (2)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .awfull   (awfull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bin   = '0;
        m_rbin  = '0;
        m_level = '0;
        m_full  = 1'b0;
        m_aw    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".waddr"},  32'(waddr),  32'd0);
        chk({tag, ".wptr"},   32'(wptr),   32'd0);
        chk({tag, ".wfull"},  32'(wfull),  32'd0);
        chk({tag, ".awfull"}, 32'(awfull), 32'd0);
        chk({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        chk({tag, ".wovf"},   32'(wovf),   32'd0);
    endtask

    // Drive one cycle, predict the registered result, then compare it
    task automatic step(input string tag, input logic w, input int rbin_i);
        exp_t e;
        exp_t got;
        @(negedge wclk);
        winc     = w;
        m_rbin   = rbin_i[4:0];
        wq2_rptr = m_rbin ^ (m_rbin >> 1);
`ifdef ASYNC_FIFO_OVF_EN
        if (w && m_full) m_ovf = 1'b1;
`endif
        if (w && !m_full) m_bin = m_bin + 5'd1;
        m_level  = m_bin - m_rbin;
        m_full   = (m_level == 5'd16);
        m_aw     = (m_level >= 5'd14);
        e.waddr  = m_bin[3:0];
        e.wptr   = m_bin ^ (m_bin >> 1);
        e.wfull  = m_full;
        e.awfull = m_aw;
        e.wlevel = m_level;
        e.wovf   = m_ovf;
        q_exp.push_back(e);
        @(posedge wclk);
        #1;
        if (q_exp.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got = q_exp.pop_front();
            chk({tag, ".waddr"},  32'(waddr),  32'(got.waddr));
            chk({tag, ".wptr"},   32'(wptr),   32'(got.wptr));
            chk({tag, ".wfull"},  32'(wfull),  32'(got.wfull));
            chk({tag, ".awfull"}, 32'(awfull), 32'(got.awfull));
            chk({tag, ".wlevel"}, 32'(wlevel), 32'(got.wlevel));
            chk({tag, ".wovf"},   32'(wovf),   32'(got.wovf));
        end
    endtask

    initial begin
        wrst     = 1'b1;
        winc     = 1'b0;
        wq2_rptr = '0;
        model_reset();
        #12;
        chk_all_zero("reset_init");
        @(negedge wclk);
        wrst = 1'b0;

        // Advance to wbin=7, then reset mid-cycle: outputs clear with no edge
        for (int i = 0; i < 7; i++) step("pre_rst_wr", 1'b1, 0);
        chk("pre_rst_waddr", 32'(waddr), 32'd7);
        #2;
        wrst = 1'b1;
        #1;
        chk_all_zero("reset_async");
        model_reset();
        @(negedge wclk);
        winc     = 1'b0;
        wq2_rptr = '0;
        wrst     = 1'b0;

        // Fill to full with the read pointer parked at 0
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 0);
        chk("fill_full", 32'(wfull), 32'd1);
        chk("fill_level", 32'(wlevel), 32'd16);

        // Writes while full are dropped
        for (int i = 0; i < 3; i++) step("drop", 1'b1, 0);
        step("drop_idle", 1'b0, 0);

        // Read pointer advances by one: full releases, level 15
        step("release", 1'b0, 1);
        chk("release_level", 32'(wlevel), 32'd15);

        // Simultaneous write and read advance at level 15
        step("simul", 1'b1, 2);
        chk("simul_level", 32'(wlevel), 32'd15);

        // Wrap: writes interleaved with matching read advances
        rb = 2;
        for (int i = 0; i < 40; i++) begin
            rb = (rb + 1) % 32;
            step("wrap", 1'b1, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wptr_full_ctrl

`default_nettype wire

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: FIFO address width; depth = 2**ADDRSIZE; legal range 2..16.
REQ-002 SHALL have parameter AFULL_LVL, default 2: free-slot margin at which awfull asserts; legal range 1..2**ADDRSIZE-1.
REQ-003 SHALL have port wclk, input, 1: write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port wrst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port winc, input, 1: write request from the write-side client.
REQ-006 SHALL have port wq2_rptr, input, ADDRSIZE+1: Gray read pointer, already synchronized into wclk by the read-to-write synchronizer.
REQ-007 SHALL have port waddr, output, ADDRSIZE: binary RAM write address.
REQ-008 SHALL have port wptr, output, ADDRSIZE+1: registered Gray write pointer sent to the write-to-read synchronizer.
REQ-009 SHALL have port wfull, output, 1: FIFO full, registered.
REQ-010 SHALL have port awfull, output, 1: almost full, registered.
REQ-011 SHALL have port wlevel, output, ADDRSIZE+1: registered fill level as seen from the write side.
REQ-012 SHALL have port wovf, output, 1: sticky overflow error.

Function
REQ-013 SHALL accept a write only when winc=1 and wfull=0; a write attempted while full is dropped and does not move any pointer.
REQ-014 SHALL compute wbinnext = wbin + accepted-write, modulo 2**(ADDRSIZE+1), and register it into wbin each cycle.
REQ-015 SHALL compute wgraynext = (wbinnext >> 1) XOR wbinnext and register it into wptr; wptr changes by exactly one bit per accepted write.
REQ-016 SHALL drive waddr = wbin[ADDRSIZE-1:0] combinationally from the register, giving zero-latency address for the current write.
REQ-017 SHALL register wfull = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}); the write that fills the last slot raises wfull on the next edge.
REQ-018 SHALL convert wq2_rptr to binary rbin and register wlevel = (wbinnext - rbin) mod 2**(ADDRSIZE+1); wlevel ranges 0..2**ADDRSIZE.
REQ-019 SHALL register awfull = (wbinnext - rbin) >= 2**ADDRSIZE - AFULL_LVL; awfull is 1 whenever wfull is 1.
REQ-020 SHALL release wfull only pessimistically: it clears on the first edge after the synchronized wq2_rptr advances, with no earlier deassertion.
REQ-021 SHALL handle pointer wrap: wbin rolls from 2**(ADDRSIZE+1)-1 to 0, and the MSB and MSB-1 inversion in REQ-017 keeps full detection correct across the wrap.
REQ-022 SHALL handle a simultaneous accepted write and read-pointer advance in one cycle: wlevel is unchanged and wfull does not assert.

Reset
REQ-023 SHALL, while wrst=1, asynchronously force wbin=0, wptr=0, waddr=0, wfull=0, awfull=0, wlevel=0, wovf=0.
REQ-024 SHALL resume on the first wclk edge after wrst deasserts; a reset in mid-operation discards all pointer state, and the read side is reset coherently by system contract.

Configuration
REQ-025 SHALL, when macro ASYNC_FIFO_OVF_EN is defined, set wovf on the edge after winc=1 while wfull=1, holding it until wrst.
REQ-026 SHALL, when ASYNC_FIFO_OVF_EN is undefined, tie wovf to 0 and synthesize no overflow register.

Structure
REQ-027 SHALL place the shared Gray/binary conversion functions and the depth constant derivation in package async_fifo_pkg.
REQ-028 SHALL instantiate one sub-module, gray2bin (parameter WIDTH), to convert wq2_rptr to rbin; all other logic is flat.

Verification
All scenarios use ADDRSIZE=4 and AFULL_LVL=2.
REQ-029 SHALL cover reset: assert wrst mid-stream with wbin=7; all outputs are 0 immediately, without waiting for a clock edge.
REQ-030 SHALL cover fill to full: 16 writes with wq2_rptr=0; wfull=1 after the 16th edge, wlevel=16, and awfull=1 from wlevel=14.
REQ-031 SHALL cover drop while full: winc held 3 cycles at full; waddr, wptr and wlevel stay unchanged; wovf=1 with ASYNC_FIFO_OVF_EN defined, 0 without.
REQ-032 SHALL cover release: at full, wq2_rptr steps Gray 0->1; wfull=0 and wlevel=15 on the next edge.
REQ-033 SHALL cover wrap: 40 writes interleaved with matching wq2_rptr advances; wptr passes 5'b10000 to 5'b00000 correctly, with no false wfull.
REQ-034 SHALL cover simultaneous events: a write and a read advance in the same cycle at wlevel=15; wlevel stays 15 and wfull stays 0.
